// File: rtl/cim_host_seq.sv
// cim_host_seq: host sequencer for the CIM macro. Loads weight rows into the
// shadow bank, swaps banks, aligns activation passes to st, returns nout.
// Ports: clk, rst (async, active-high), inwidth (0: 12-cycle pass, 1: 24),
//   w_valid/w_ready/w_data weight rows, x_valid/x_ready/x_data activations,
//   r_valid/r_ready/r_data results, D/WA/cima/acm_en/xin0 macro drive,
//   st/nout macro feedback.
// Optional: define CIM_HOST_SEQ_PERF_EN to add pass_cnt[15:0] and drop_cnt[7:0].
module cim_host_seq #(
  parameter int ROWS    = 8,
  parameter int DW      = 24,
  parameter int XW      = 96,
  parameter int NW      = 51,
  parameter int CAP_LAT = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inwidth,
  input  logic            w_valid,
  output logic            w_ready,
  input  logic [DW-1:0]   w_data,
  input  logic            x_valid,
  output logic            x_ready,
  input  logic [XW-1:0]   x_data,
  output logic            r_valid,
  input  logic            r_ready,
  output logic [NW-1:0]   r_data,
  output logic [DW-1:0]   D,
  output logic [ROWS-1:0] WA,
  output logic            cima,
  output logic            acm_en,
  output logic [XW-1:0]   xin0,
  input  logic            st,
  input  logic [NW-1:0]   nout
`ifdef CIM_HOST_SEQ_PERF_EN
  ,
  output logic [15:0]     pass_cnt,
  output logic [7:0]      drop_cnt
`endif
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CL = (CAP_LAT > 0) ? CAP_LAT - 1 : 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SWAP,
    S_ALIGN,
    S_RUN,
    S_CAP
  } state_t;

  state_t            state_q, state_d;
  logic [RW-1:0]     r_q, r_d;
  logic              swp_q, swp_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [DW-1:0]     d_q, d_d;
  logic [ROWS-1:0]   wa_q, wa_d;
  logic              cima_q, cima_d;
  logic              acm_q, acm_d;
  logic [XW-1:0]     xin_q, xin_d;
  logic [NW-1:0]     rdat_q, rdat_d;
  logic              rv_q, rv_d;

  logic              w_acc;
  logic              x_acc;
  logic [4:0]        p_last;

  // Readies come from the state register; weights beat activations in IDLE,
  // and a new pass is only taken when the result slot is free or draining.
  always_comb begin
    w_ready = !rst && (state_q == S_IDLE || state_q == S_LOAD);
    x_ready = !rst && (state_q == S_IDLE) && !w_valid
              && (!rv_q || r_ready);
    w_acc   = w_valid && w_ready;
    x_acc   = x_valid && x_ready;
    p_last  = inwidth ? 5'd24 : 5'd12;
  end

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    swp_d   = swp_q;
    cnt_d   = cnt_q;
    d_d     = d_q;
    wa_d    = '0;
    cima_d  = cima_q;
    acm_d   = acm_q;
    xin_d   = xin_q;
    rdat_d  = rdat_q;
    rv_d    = rv_q;

    if (rv_q && r_ready) rv_d = 1'b0;

    unique case (state_q)
      S_IDLE, S_LOAD: begin
        if (w_acc) begin
          d_d       = w_data;
          wa_d[r_q] = 1'b1;
          if (r_q == RW'(ROWS - 1)) begin
            r_d     = '0;
            swp_d   = 1'b0;
            state_d = S_SWAP;
          end else begin
            r_d     = r_q + RW'(1);
            state_d = S_LOAD;
          end
        end else if (x_acc) begin
          xin_d   = x_data;
          state_d = S_ALIGN;
        end
      end
      // First SWAP cycle shows the last WA pulse; the bank flips only
      // after WA has been idle for a cycle.
      S_SWAP: begin
        if (!swp_q) begin
          swp_d = 1'b1;
        end else begin
          swp_d   = 1'b0;
          cima_d  = !cima_q;
          state_d = S_IDLE;
        end
      end
      S_ALIGN: begin
        if (st) begin
          acm_d   = 1'b1;
          cnt_d   = 5'd1;
          state_d = S_RUN;
        end
      end
      // The st cycle in ALIGN is pass cycle 0; st must recur on cycle P.
      S_RUN: begin
        if (cnt_q == p_last) begin
          acm_d   = 1'b0;
          cnt_d   = '0;
          state_d = st ? S_CAP : S_ALIGN;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      S_CAP: begin
        if (cnt_q == 5'(CL)) begin
          rdat_d  = nout;
          rv_d    = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      r_q     <= '0;
      swp_q   <= 1'b0;
      cnt_q   <= '0;
      d_q     <= '0;
      wa_q    <= '0;
      cima_q  <= 1'b0;
      acm_q   <= 1'b0;
      xin_q   <= '0;
      rdat_q  <= '0;
      rv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      swp_q   <= swp_d;
      cnt_q   <= cnt_d;
      d_q     <= d_d;
      wa_q    <= wa_d;
      cima_q  <= cima_d;
      acm_q   <= acm_d;
      xin_q   <= xin_d;
      rdat_q  <= rdat_d;
      rv_q    <= rv_d;
    end
  end

  assign D       = d_q;
  assign WA      = wa_q;
  assign cima    = cima_q;
  assign acm_en  = acm_q;
  assign xin0    = xin_q;
  assign r_data  = rdat_q;
  assign r_valid = rv_q;

`ifdef CIM_HOST_SEQ_PERF_EN
  logic [15:0] pc_q, pc_d;
  logic [7:0]  dc_q, dc_d;
  logic        drop;

  always_comb begin
    drop = (state_q == S_RUN) && (cnt_q == p_last) && !st;
    pc_d = pc_q;
    dc_d = dc_q;
    if (rv_d && !rv_q && pc_q != 16'hFFFF) pc_d = pc_q + 16'd1;
    if (drop && dc_q != 8'hFF) dc_d = dc_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= '0;
      dc_q <= '0;
    end else begin
      pc_q <= pc_d;
      dc_q <= dc_d;
    end
  end

  assign pass_cnt = pc_q;
  assign drop_cnt = dc_q;
`endif

endmodule

// File: tb/tb_cim_host_seq.sv
// tb_cim_host_seq: directed bench for cim_host_seq with a result scoreboard.
// Drives weight loads, aligned/late passes and result back-pressure.
module tb_cim_host_seq;

  localparam int ROWS = 8;
  localparam int DW   = 24;
  localparam int XW   = 96;
  localparam int NW   = 51;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            inwidth = 1'b0;
  logic            w_valid = 1'b0;
  logic            w_ready;
  logic [DW-1:0]   w_data = '0;
  logic            x_valid = 1'b0;
  logic            x_ready;
  logic [XW-1:0]   x_data = '0;
  logic            r_valid;
  logic            r_ready = 1'b1;
  logic [NW-1:0]   r_data;
  logic [DW-1:0]   D;
  logic [ROWS-1:0] WA;
  logic            cima;
  logic            acm_en;
  logic [XW-1:0]   xin0;
  logic            st = 1'b0;
  logic [NW-1:0]   nout = '0;
`ifdef CIM_HOST_SEQ_PERF_EN
  logic [15:0]     pass_cnt;
  logic [7:0]      drop_cnt;
`endif

  int vec  = 0;
  int miss = 0;
  logic [NW-1:0] sb_q[$];

  always #5 clk = ~clk;

  cim_host_seq dut (
    .clk(clk), .rst(rst), .inwidth(inwidth),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data),
    .D(D), .WA(WA), .cima(cima), .acm_en(acm_en), .xin0(xin0),
    .st(st), .nout(nout)
`ifdef CIM_HOST_SEQ_PERF_EN
    , .pass_cnt(pass_cnt), .drop_cnt(drop_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every completed result handshake pops one expectation.
  always @(negedge clk) begin
    if (!rst && r_valid && r_ready) begin
      if (sb_q.size() == 0) begin
        chk("r_extra", 128'(sb_q.size()), 128'd1);
      end else begin
        logic [NW-1:0] e;
        e = sb_q.pop_front();
        chk("r_data", 128'(r_data), 128'(e));
      end
    end
  end

  task automatic load(input int gap_at, input int gap_len,
                      input logic [DW-1:0] base);
    logic c0;
    logic c1;
    c0 = cima;
    c1 = !cima;
    for (int i = 0; i < ROWS; i++) begin
      if (i == gap_at) begin
        w_valid = 1'b0;
        for (int g = 0; g < gap_len; g++) begin
          tick();
          chk("wa_gap", 128'(WA), 128'd0);
          chk("w_ready_gap", 128'(w_ready), 128'd1);
        end
      end
      w_valid = 1'b1;
      w_data  = base + DW'(i);
      tick();
      chk("wa_row", 128'(WA), 128'(1 << i));
      chk("d_row", 128'(D), 128'(base + DW'(i)));
      if (i < ROWS - 1) chk("cima_load", 128'(cima), 128'(c0));
    end
    w_valid = 1'b0;
    chk("cima_swap", 128'(cima), 128'(c0));
    tick();
    chk("wa_off", 128'(WA), 128'd0);
    chk("cima_hold", 128'(cima), 128'(c0));
    tick();
    chk("cima_tog", 128'(cima), 128'(c1));
    chk("w_ready_idle", 128'(w_ready), 128'd1);
  endtask

  // One pass: accept x, wait in ALIGN, optionally miss the closing st by
  // `late` cycles (discarded pass, then realign), then a clean pass.
  task automatic pass(input logic [XW-1:0] x, input logic [NW-1:0] n,
                      input int wait0, input int late, input logic iw);
    int p;
    p = iw ? 24 : 12;
    inwidth = iw;
    nout    = n;
    x_valid = 1'b1;
    x_data  = x;
    #1;
    chk("x_ready", 128'(x_ready), 128'd1);
    tick();
    x_valid = 1'b0;
    sb_q.push_back(n);
    chk("xin0_lat", 128'(xin0), 128'(x));
    chk("acm_align", 128'(acm_en), 128'd0);
    for (int k = 0; k < wait0; k++) begin
      tick();
      chk("acm_wait", 128'(acm_en), 128'd0);
    end
    st = 1'b1;
    tick();
    st = 1'b0;
    if (late > 0) begin
      for (int k = 1; k <= p; k++) begin
        chk("acm_drop_run", 128'(acm_en), 128'd1);
        tick();
      end
      chk("acm_dropped", 128'(acm_en), 128'd0);
      chk("rv_dropped", 128'(r_valid), 128'd0);
      for (int k = 1; k < late; k++) begin
        tick();
        chk("rv_realign", 128'(r_valid), 128'd0);
        chk("xin0_keep", 128'(xin0), 128'(x));
      end
      st = 1'b1;
      tick();
      st = 1'b0;
    end
    for (int k = 1; k < p; k++) begin
      chk("acm_run", 128'(acm_en), 128'd1);
      chk("xin0_run", 128'(xin0), 128'(x));
      tick();
    end
    chk("acm_last", 128'(acm_en), 128'd1);
    st = 1'b1;
    tick();
    st = 1'b0;
    chk("acm_off", 128'(acm_en), 128'd0);
    chk("rv_cap", 128'(r_valid), 128'd0);
    tick();
    chk("r_valid", 128'(r_valid), 128'd1);
  endtask

  initial begin
    // Reset state
    x_valid = 1'b1;
    tick();
    tick();
    chk("rst_wa", 128'(WA), 128'd0);
    chk("rst_d", 128'(D), 128'd0);
    chk("rst_cima", 128'(cima), 128'd0);
    chk("rst_acm", 128'(acm_en), 128'd0);
    chk("rst_xin0", 128'(xin0), 128'd0);
    chk("rst_rdata", 128'(r_data), 128'd0);
    chk("rst_rvalid", 128'(r_valid), 128'd0);
    chk("rst_wready", 128'(w_ready), 128'd0);
    chk("rst_xready", 128'(x_ready), 128'd0);
    x_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("idle_wready", 128'(w_ready), 128'd1);
    chk("idle_xready", 128'(x_ready), 128'd1);

    // Weights beat activations in IDLE
    w_valid = 1'b1;
    x_valid = 1'b1;
    #1;
    chk("prio_xready", 128'(x_ready), 128'd0);
    w_valid = 1'b0;
    x_valid = 1'b0;

    // Back-to-back load, then load with a 5-cycle gap
    load(ROWS, 0, 24'h000001);
    load(4, 5, 24'h000100);

    // Reset in the middle of a load
    w_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      w_data = 24'h000200 + 24'(i);
      tick();
    end
    w_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_wready", 128'(w_ready), 128'd0);
    tick();
    chk("mid_wa", 128'(WA), 128'd0);
    chk("mid_d", 128'(D), 128'd0);
    chk("mid_cima", 128'(cima), 128'd0);
    rst = 1'b0;
    tick();
    load(ROWS, 0, 24'h000300);
    chk("fresh_cima", 128'(cima), 128'd1);

    // Aligned pass, inwidth=0
    r_ready = 1'b1;
    pass({8{12'hABC}}, 51'd1234, 3, 0, 1'b0);
    tick();

    // Back-pressure: result held, next x waits for the drain
    r_ready = 1'b0;
    pass({8{12'h123}}, 51'h5_5555_5555_5555, 0, 0, 1'b0);
    x_valid = 1'b1;
    x_data  = {8{12'hFED}};
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("hold_xready", 128'(x_ready), 128'd0);
      tick();
      chk("hold_rvalid", 128'(r_valid), 128'd1);
      chk("hold_xin0", 128'(xin0), 128'({8{12'h123}}));
    end
    r_ready = 1'b1;
    pass({8{12'hFED}}, 51'h7_0000_0000_0ABC, 1, 0, 1'b1);
    tick();
    tick();

    // Late st: discarded pass, then realigned result
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    pass({8{12'h5A5}}, 51'd98765, 2, 2, 1'b0);
    tick();
    tick();
    chk("sb_empty", 128'(sb_q.size()), 128'd0);
`ifdef CIM_HOST_SEQ_PERF_EN
    chk("pass_cnt", 128'(pass_cnt), 128'd1);
    chk("drop_cnt", 128'(drop_cnt), 128'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
